// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-requester memory port arbiter: FSM state
// encodings, byte-enable width and the round-robin pick rule.
package mem_port_arbiter_pkg;

  localparam int WE_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  // Winner of an arbitration round: a lone requester always wins; when both
  // request, the one not served last wins.
  function automatic logic arb_pick(input logic req0, input logic req1,
                                    input logic last_grant);
    logic winner;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = req1;
    end
    return winner;
  endfunction

  // Grant state belonging to a requester index.
  function automatic arb_state_e grant_state(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input word multiplexer used to steer the granted requester's payload
// onto the shared memory port.
module mem_port_arbiter_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  // Select b when sel is high, otherwise a.
  always_comb begin
    y_o = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// (requester 0) and the data memory stage (requester 1). A grant is held
// until the memory acks; on ack the next grant is chosen in the same edge,
// so back-to-back transactions carry no idle bubble.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // Requester 0: instruction fetch
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [WE_WIDTH-1:0]   m0_we,
  output logic                  m0_ack,
  // Requester 1: data memory stage
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [WE_WIDTH-1:0]   m1_we,
  output logic                  m1_ack,
  // Read data broadcast to both requesters
  output logic [DATA_WIDTH-1:0] m_rdata,
  // Shared memory port
  output logic                  s_req,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [WE_WIDTH-1:0]   s_we,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ack
);

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_sel_q, grant_sel_d;
  logic                 any_req;
  logic [WE_WIDTH-1:0]  mux_we;

  assign any_req = m0_req | m1_req;

  // Next-state and round-robin bookkeeping.
  // NOTE: every signal gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = grant_state(arb_pick(m0_req, m1_req, last_grant_q));
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        // Grant is held until the memory completes; a dropped request is
        // ignored so the in-flight transaction is never abandoned.
        if (s_ack) begin
          last_grant_d = (state_q == ST_GRANT1);
          if (any_req) begin
            state_d = grant_state(arb_pick(m0_req, m1_req, last_grant_d));
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_sel_d = (state_d == ST_GRANT1);
  end

  // State, last-served requester and registered payload select.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset puts the arbiter idle with requester 0
  // favoured for the first round.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_sel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_sel_q  <= grant_sel_d;
    end
  end

  mem_port_arbiter_mux2 #(.WIDTH(ADDR_WIDTH)) u_mux_addr (
    .a_i   (m0_addr),
    .b_i   (m1_addr),
    .sel_i (grant_sel_q),
    .y_o   (s_addr)
  );

  mem_port_arbiter_mux2 #(.WIDTH(DATA_WIDTH)) u_mux_wdata (
    .a_i   (m0_wdata),
    .b_i   (m1_wdata),
    .sel_i (grant_sel_q),
    .y_o   (s_wdata)
  );

  mem_port_arbiter_mux2 #(.WIDTH(WE_WIDTH)) u_mux_we (
    .a_i   (m0_we),
    .b_i   (m1_we),
    .sel_i (grant_sel_q),
    .y_o   (mux_we)
  );

  // Port outputs: write enables are forced off while idle so no stray write
  // reaches memory; acks are routed only to the requester holding the grant.
  always_comb begin
    s_req   = (state_q != ST_IDLE);
    s_we    = s_req ? mux_we : '0;
    m0_ack  = s_ack && (state_q == ST_GRANT0);
    m1_ack  = s_ack && (state_q == ST_GRANT1);
    m_rdata = s_rdata;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the data buses.
REQ-002 Parameter: ADDR_WIDTH, default 30, width of the word address buses.
REQ-003 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: m0_req  input  1  requester 0 (instruction fetch) transaction request.
REQ-006 Port: m0_addr  input  ADDR_WIDTH  requester 0 word address.
REQ-007 Port: m0_wdata  input  DATA_WIDTH  requester 0 write data.
REQ-008 Port: m0_we  input  4  requester 0 byte write enables; 0 means read.
REQ-009 Port: m0_ack  output  1  requester 0 transaction complete.
REQ-010 Ports m1_req, m1_addr, m1_wdata, m1_we, m1_ack SHALL mirror REQ-005..009 for requester 1 (data memory stage).
REQ-011 Port: m_rdata  output  DATA_WIDTH  read data, broadcast to both requesters.
REQ-012 Port: s_req  output  1  shared memory port request.
REQ-013 Port: s_addr  output  ADDR_WIDTH; s_wdata  output  DATA_WIDTH; s_we  output  4  muxed from the granted requester.
REQ-014 Port: s_rdata  input  DATA_WIDTH; s_ack  input  1  memory completion, valid one cycle.

Function
REQ-015 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-016 IDLE: with any mN_req high, the next state SHALL be GRANTn for the winner; with none, IDLE.
REQ-017 Arbitration SHALL be round-robin: a 1-bit last_grant register selects the requester not served last when both request; a lone requester always wins.
REQ-018 In GRANTn: s_req=1 and s_addr/s_wdata/s_we equal requester n's inputs; in IDLE: s_req=0 and s_we=0.
REQ-019 mN_ack SHALL equal s_ack AND (state==GRANTn), combinationally; m_rdata SHALL equal s_rdata.
REQ-020 On s_ack in GRANTn, last_grant<=n and the next state SHALL be chosen by REQ-016/017 from the current requests, with no IDLE bubble (back-to-back grants).
REQ-021 Minimum latency: request seen in IDLE at edge k, s_req high after edge k, ack no earlier than the cycle after edge k.
REQ-022 Requesters SHALL hold req and payload stable until ack; a deasserted req in GRANTn SHALL be ignored, and the grant SHALL be held until s_ack.
REQ-023 s_ack in IDLE SHALL be ignored and SHALL produce no mN_ack.
REQ-024 A grant SHALL never be preempted; the other request waits, bounded by one transaction when both request continuously.

Reset
REQ-025 reset_n low SHALL immediately force state=IDLE, last_grant=1 (requester 0 first after reset), s_req=0, s_we=0, m0_ack=m1_ack=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it; no ack is generated for it after release.
REQ-027 The first grant evaluation SHALL be at the first rising edge after reset_n deasserts.

Structure
REQ-028 FSM state encodings SHALL reside in the shared constants file used by the core.
REQ-029 Payload muxing SHALL use the existing mux2 sub-module (instances for addr, wdata, we), selected by a registered grant bit.

Verification
REQ-030 Single read: m0_req=1, addr=0x100, slave acks 2 cycles later with 0xDEADBEEF -> m0_ack one cycle, m_rdata=0xDEADBEEF, m1_ack=0.
REQ-031 Simultaneous requests after reset -> requester 0 granted first, then requester 1 immediately after s_ack, no IDLE cycle.
REQ-032 Both requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-033 m1 write, addr=0x3C, wdata=0x12345678, we=4'b1111 -> s_we=4'b1111, s_wdata=0x12345678 until s_ack; then s_we=0.
REQ-034 reset_n pulsed low during GRANT1 before s_ack -> s_req=0 at once, no m1_ack, IDLE after release.
REQ-035 Spurious s_ack in IDLE -> both mN_ack stay 0, state stays IDLE.
